// File: rtl/apb_mem_slave.sv
// apb_mem_slave: word-addressed RAM behind an APB slave port.
//  - Programmable wait states (WAIT_STATES, 0..15) before PREADY.
//  - Out-of-range accesses (PADDR >= MEM_DEPTH) complete with PSLVERR and never touch memory.
//  - PRDATA is registered at the setup edge of a read and holds otherwise.
//  - Optional macro APB_PSTRB_EN adds the PSTRB port for byte-lane writes; without it
//    every accepted write replaces the full word.
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable in the range compare.
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0]          WS    = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [3:0]            wcnt;
  logic [IDX_W-1:0]      addr_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [NB-1:0]         strb;
  logic                  addr_err;
  logic                  setup;
  logic                  complete;
  logic                  wr_en;
  logic [3:0]            wcnt_nxt;
  logic                  ready_nxt;

  // Replace only the byte lanes selected by lanes[i]; the rest keep old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lanes
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) begin
        r[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return r;
  endfunction

`ifdef APB_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = '1;
`endif

  assign addr_err  = ({1'b0, PADDR} >= DEPTH);
  assign setup     = (state == IDLE) && PSEL && !PENABLE;
  assign complete  = (state == ACCESS) && PSEL && PENABLE && PREADY;
  // Reset on the completion edge drops the transfer, so the write is gated by PRESET.
  assign wr_en     = complete && wr_q && !err_q && !PRESET;
  assign wcnt_nxt  = wcnt + 4'd1;
  assign ready_nxt = (wcnt_nxt == WS);

  // Memory array: committed only on a successful write completion, never reset.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      mem[addr_q] <= merge_lanes(mem[addr_q], PWDATA, strb);
    end
  end

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // PENABLE high without a setup phase is not a transfer start.
          if (setup) begin
            state   <= ACCESS;
            addr_q  <= PADDR[IDX_W-1:0];
            wr_q    <= PWRITE;
            err_q   <= addr_err;
            wcnt    <= 4'd0;
            PREADY  <= (WS == 4'd0);
            PSLVERR <= (WS == 4'd0) && addr_err;
            if (!PWRITE) begin
              PRDATA <= addr_err ? '0 : mem[PADDR[IDX_W-1:0]];
            end
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // Master abandoned the transfer: no write, no error.
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (complete) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (!PREADY) begin
            wcnt    <= wcnt_nxt;
            PREADY  <= ready_nxt;
            PSLVERR <= ready_nxt && err_q;
          end
        end
        default: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (WAIT_STATES 0, 2, 3) driven one at a time.
// A transaction-level model predicts PREADY/PSLVERR/PRDATA for every cycle; a negedge
// process compares all instances each cycle. Literal checks pin key values.
module tb_apb_mem_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NB = DW / 8;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [2:0]           psel, penable, pwrite, pready, pslverr;
  logic [2:0][AW-1:0]   paddr;
  logic [2:0][DW-1:0]   pwdata, prdata;
`ifdef APB_PSTRB_EN
  logic [2:0][NB-1:0]   pstrb;
`endif

  int checks = 0;
  int errors = 0;

  int              ws_tab [3] = '{0, 2, 3};
  logic [DW-1:0]   mdl_mem [3][DEPTH];
  logic [2:0]      exp_ready, exp_err;
  logic [2:0][DW-1:0] exp_rdata;
  bit              chk_en = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_mem_slave #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
      .WAIT_STATES(g == 0 ? 0 : g + 1)
    ) u_dut (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[g]), .PENABLE(penable[g]),
      .PWRITE(pwrite[g]), .PADDR(paddr[g]), .PWDATA(pwdata[g]),
`ifdef APB_PSTRB_EN
      .PSTRB(pstrb[g]),
`endif
      .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g])
    );
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdl_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] s);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("pready[%0d]", k), DW'(pready[k]), DW'(exp_ready[k]));
        chk($sformatf("pslverr[%0d]", k), DW'(pslverr[k]), DW'(exp_err[k]));
        chk($sformatf("prdata[%0d]", k), prdata[k], exp_rdata[k]);
      end
    end
  end

  // Reset for n edges; all called at posedge+1.
  task automatic do_reset(input int n);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ready = '0;
    exp_err   = '0;
    exp_rdata = '0;
    chk_en    = 1'b1;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    rst     = 1'b0;
    psel    = '0;
    penable = '0;
  endtask

  // One APB transfer on instance k. abort_after >= 0 drops PSEL after that many
  // access cycles. Returns DUT-observed wait cycles and PSLVERR at PREADY.
  task automatic xfer(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] s, input int abort_after,
                      output int dut_wait, output bit err_seen);
    int  ws;
    bit  err;
    bit  done;
    ws  = ws_tab[k];
    err = (int'(a) >= DEPTH);
    dut_wait = 0;
    err_seen = 1'b0;
    done = 1'b0;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
`ifdef APB_PSTRB_EN
    pstrb[k] = s;
`endif
    @(posedge clk); #1;
    if (!wr) exp_rdata[k] = err ? '0 : mdl_mem[k][a[5:0]];
    exp_ready[k] = (ws == 0);
    exp_err[k]   = (ws == 0) && err;
    penable[k] = 1'b1;
    // Address and direction must be ignored once latched.
    paddr[k]  = ~a;
    pwrite[k] = ~wr;
    for (int i = 0; i <= ws && !done; i++) begin
      if (i == abort_after) begin
        psel[k] = 1'b0; penable[k] = 1'b0;
      end
      @(negedge clk);
      if (!pready[k]) dut_wait++;
      else err_seen = pslverr[k];
      @(posedge clk); #1;
      if (i == abort_after) begin
        exp_ready[k] = 1'b0; exp_err[k] = 1'b0;
        done = 1'b1;
      end else if (i == ws) begin
        if (wr && !err) mdl_mem[k][a[5:0]] = mdl_merge(mdl_mem[k][a[5:0]], d, s);
        exp_ready[k] = 1'b0; exp_err[k] = 1'b0;
        psel[k] = 1'b0; penable[k] = 1'b0;
        done = 1'b1;
      end else begin
        exp_ready[k] = (i + 1 == ws);
        exp_err[k]   = (i + 1 == ws) && err;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  w;
    bit  e;
    rst = 1'b0;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb = '0;
`endif
    exp_ready = '0; exp_err = '0; exp_rdata = '0;
    @(posedge clk); #1;
    do_reset(2);
    chk("reset_prdata", prdata[0], 32'h0);
    chk("reset_pready", DW'(pready[0]), 32'h0);

    // Reset in the middle of a write to addr 5.
    xfer(0, 1'b1, 8'd5, 32'h5555AAAA, '1, -1, w, e);
    xfer(0, 1'b0, 8'd5, 32'h0, '1, -1, w, e);
    chk("t1_pre_rdata", prdata[0], 32'h5555AAAA);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'd5; pwdata[0] = 32'hBAD0BAD0;
    @(posedge clk); #1;
    exp_ready[0] = 1'b1; exp_err[0] = 1'b0;
    penable[0] = 1'b1;
    do_reset(2);
    chk("t1_rst_prdata", prdata[0], 32'h0);
    chk("t1_rst_pready", DW'(pready[0]), 32'h0);
    chk("t1_rst_pslverr", DW'(pslverr[0]), 32'h0);
    xfer(0, 1'b0, 8'd5, 32'h0, '1, -1, w, e);
    chk("t1_no_write", prdata[0], 32'h5555AAAA);

    // Zero-wait write then read.
    xfer(0, 1'b1, 8'd3, 32'hDEADBEEF, '1, -1, w, e);
    chk("t2_wr_wait", DW'(w), 32'd0);
    xfer(0, 1'b0, 8'd3, 32'h0, '1, -1, w, e);
    chk("t2_rd_wait", DW'(w), 32'd0);
    chk("t2_rd_err", DW'(e), 32'd0);
    chk("t2_rdata", prdata[0], 32'hDEADBEEF);

    // Three wait states.
    xfer(2, 1'b1, 8'd0, 32'h0BADF00D, '1, -1, w, e);
    xfer(2, 1'b0, 8'd0, 32'h0, '1, -1, w, e);
    chk("t3_wait", DW'(w), 32'd3);
    chk("t3_rdata", prdata[2], 32'h0BADF00D);

    // Out-of-range accesses.
    xfer(0, 1'b1, 8'd0, 32'hA5A50F0F, '1, -1, w, e);
    xfer(0, 1'b1, 8'd64, 32'h12345678, '1, -1, w, e);
    chk("t4_wr_err", DW'(e), 32'd1);
    xfer(0, 1'b0, 8'd64, 32'h0, '1, -1, w, e);
    chk("t4_rd_err", DW'(e), 32'd1);
    chk("t4_rd_data", prdata[0], 32'h0);
    xfer(0, 1'b0, 8'd0, 32'h0, '1, -1, w, e);
    chk("t4_word0", prdata[0], 32'hA5A50F0F);
    xfer(2, 1'b0, 8'd200, 32'h0, '1, -1, w, e);
    chk("t4_ws3_err", DW'(e), 32'd1);

    // Back-to-back transfers.
    xfer(0, 1'b1, 8'd7, 32'h77777777, '1, -1, w, e);
    xfer(0, 1'b1, 8'd8, 32'h88888888, '1, -1, w, e);
    xfer(0, 1'b0, 8'd7, 32'h0, '1, -1, w, e);
    chk("t5_rd7", prdata[0], 32'h77777777);
    xfer(0, 1'b0, 8'd8, 32'h0, '1, -1, w, e);
    chk("t5_rd8", prdata[0], 32'h88888888);
    chk("t5_wait", DW'(w), 32'd0);

    // Abort with two wait states.
    xfer(1, 1'b1, 8'd4, 32'h44444444, '1, -1, w, e);
    xfer(1, 1'b1, 8'd4, 32'h99999999, '1, 1, w, e);
    xfer(1, 1'b0, 8'd4, 32'h0, '1, -1, w, e);
    chk("t5_abort_rd", prdata[1], 32'h44444444);
    chk("t5_abort_wait", DW'(w), 32'd2);

    // PENABLE without setup is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'd3;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("stray_pready", DW'(pready[0]), 32'h0);
    chk("stray_prdata", prdata[0], 32'h88888888);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;

`ifdef APB_PSTRB_EN
    xfer(0, 1'b1, 8'd9, 32'hAABBCCDD, 4'b1111, -1, w, e);
    xfer(0, 1'b1, 8'd9, 32'h11223344, 4'b0101, -1, w, e);
    xfer(0, 1'b0, 8'd9, 32'h0, 4'b0000, -1, w, e);
    chk("t6_strb", prdata[0], 32'hAA22CC44);
    xfer(0, 1'b1, 8'd9, 32'hFFFFFFFF, 4'b0000, -1, w, e);
    chk("t6_strb0_err", DW'(e), 32'd0);
    xfer(0, 1'b0, 8'd9, 32'h0, 4'b1111, -1, w, e);
    chk("t6_strb0", prdata[0], 32'hAA22CC44);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
